// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock on a start/done handshake.
// Shift-left {A,Q} pair, subtract-and-test against M, down-counter of remaining iterations.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  // The partial remainder never reaches M, so its top bit is always zero and is not stored;
  // the (WIDTH+1)-bit shifted value As is rebuilt from it each iteration.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   as_s;
  logic [WIDTH:0]   diff_s;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    as_s    = {a_q, q_q[WIDTH-1]};
    diff_s  = as_s - {1'b0, m_q};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            count_d = CNT_W'(WIDTH);
            state_d = ST_CALC;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // Negative trial difference means M did not fit: keep the shifted value, quotient bit 0.
        if (diff_s[WIDTH]) begin
          a_d = as_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          a_d = diff_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          quot_d  = q_d;
          rem_d   = a_d;
          dbz_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
